// File: rtl/block_ram_fill.sv
// Simple-dual-port RAM with lane write enables, 1-cycle registered read and a constant-fill sweep engine.
// Reads take 1 cycle and run every cycle; user writes are dropped while o_busy (fill + done cycle) is high.
module block_ram_fill #(
  parameter string INIT_FILE   = "",
  parameter int    AddrBusSize = 9,
  parameter int    NumElements = 512,
  parameter int    ElementSize = 8,
  parameter int    LaneSize    = 8,
  parameter bit    WriteFirst  = 1'b0
) (
  input  logic                              i_CLK,
  input  logic                              i_RST_n,
  input  logic                              i_write_en,
  input  logic [ElementSize/LaneSize-1:0]   i_write_lanes,
  input  logic [AddrBusSize-1:0]            i_write_addr,
  input  logic [ElementSize-1:0]            i_write_data,
  input  logic                              i_read_en,
  input  logic [AddrBusSize-1:0]            i_read_addr,
  output logic [ElementSize-1:0]            o_read_data,
  output logic                              o_read_valid,
  input  logic                              i_fill_start,
  input  logic [ElementSize-1:0]            i_fill_data,
  output logic                              o_busy,
  output logic                              o_fill_done
);

  localparam int Lanes = ElementSize / LaneSize;
  localparam logic [AddrBusSize:0]   NUM_EL   = (AddrBusSize + 1)'(NumElements);
  // Terminal count compared directly so a full 2^AddrBusSize sweep never relies on wrap.
  localparam logic [AddrBusSize-1:0] LAST_IDX = AddrBusSize'(NumElements - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_t;

  logic [ElementSize-1:0] mem [NumElements];

  state_t                 state_q, state_d;
  logic [AddrBusSize-1:0] cnt_q, cnt_d;
  logic [ElementSize-1:0] fill_dat_q, fill_dat_d;
  logic [ElementSize-1:0] rd_dat_q, rd_dat_d;
  logic                   rd_vld_q, rd_vld_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   wr_en;
  logic [AddrBusSize-1:0] wr_addr;
  logic [ElementSize-1:0] wr_dat;
  logic [Lanes-1:0]       wr_lanes;

  logic                   rd_in_range;
  logic                   wr_in_range;
  logic [AddrBusSize-1:0] rd_idx;
  logic [ElementSize-1:0] rd_word;

  assign rd_in_range = {1'b0, i_read_addr} < NUM_EL;
  assign wr_in_range = {1'b0, i_write_addr} < NUM_EL;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_dat_d = fill_dat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_fill_start) begin
          state_d    = ST_FILL;
          cnt_d      = '0;
          fill_dat_d = i_fill_data;
        end
      end
      ST_FILL: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AddrBusSize'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // The fill engine owns the write port for the whole sweep; reset blocks every write.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = i_write_addr;
    wr_dat   = i_write_data;
    wr_lanes = i_write_lanes;
    if (state_q == ST_FILL) begin
      wr_en    = i_RST_n;
      wr_addr  = cnt_q;
      wr_dat   = fill_dat_q;
      wr_lanes = '1;
    end else if (state_q == ST_IDLE) begin
      wr_en = i_RST_n & i_write_en & wr_in_range;
    end
  end

  always_comb begin
    rd_idx  = rd_in_range ? i_read_addr : '0;
    rd_word = mem[rd_idx];
    if (WriteFirst && wr_en && (wr_addr == i_read_addr)) begin
      for (int k = 0; k < Lanes; k++) begin
        if (wr_lanes[k]) rd_word[k*LaneSize +: LaneSize] = wr_dat[k*LaneSize +: LaneSize];
      end
    end
    rd_vld_d = i_read_en;
    rd_dat_d = rd_dat_q;
    if (i_read_en) rd_dat_d = rd_in_range ? rd_word : '0;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fill_dat_q <= '0;
      rd_dat_q   <= '0;
      rd_vld_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_dat_q <= fill_dat_d;
      rd_dat_q   <= rd_dat_d;
      rd_vld_q   <= rd_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (wr_en) begin
      for (int k = 0; k < Lanes; k++) begin
        if (wr_lanes[k]) mem[wr_addr][k*LaneSize +: LaneSize] <= wr_dat[k*LaneSize +: LaneSize];
      end
    end
  end

  assign o_read_data  = rd_dat_q;
  assign o_read_valid = rd_vld_q;
  assign o_busy       = busy_q;
  assign o_fill_done  = done_q;

endmodule

// File: tb/tb_block_ram_fill.sv
// Two RAM instances (512 deep read-old, 300 deep read-new) share one stimulus stream
// and are compared every cycle against an element-array model plus directed constants.
module tb_block_ram_fill;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [1:0]  wlanes;
  logic [8:0]  waddr;
  logic [15:0] wdata;
  logic        re;
  logic [8:0]  raddr;
  logic        start;
  logic [15:0] fill_data;

  logic [15:0] rd0, rd1;
  logic        vld0, vld1, busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;

  block_ram_fill #(.AddrBusSize(9), .NumElements(512), .ElementSize(16), .LaneSize(8), .WriteFirst(1'b0)) dut0 (
    .i_CLK(clk), .i_RST_n(rst_n), .i_write_en(we), .i_write_lanes(wlanes), .i_write_addr(waddr),
    .i_write_data(wdata), .i_read_en(re), .i_read_addr(raddr), .o_read_data(rd0), .o_read_valid(vld0),
    .i_fill_start(start), .i_fill_data(fill_data), .o_busy(busy0), .o_fill_done(done0));

  block_ram_fill #(.AddrBusSize(9), .NumElements(300), .ElementSize(16), .LaneSize(8), .WriteFirst(1'b1)) dut1 (
    .i_CLK(clk), .i_RST_n(rst_n), .i_write_en(we), .i_write_lanes(wlanes), .i_write_addr(waddr),
    .i_write_data(wdata), .i_read_en(re), .i_read_addr(raddr), .o_read_data(rd1), .o_read_valid(vld1),
    .i_fill_start(start), .i_fill_data(fill_data), .o_busy(busy1), .o_fill_done(done1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: element arrays plus the edge number at which each fill was accepted.
  logic [15:0] mmem [2][512];
  logic [15:0] fill_v [2];
  int          fill_s [2];
  bit          fill_act [2];
  logic [15:0] exp_rd [2];
  logic        exp_vld [2], exp_busy [2], exp_done [2];
  int          ecnt = 0;

  function automatic int n_of(input int i);
    return (i == 0) ? 512 : 300;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] ln);
    logic [15:0] r;
    r = old;
    for (int l = 0; l < 2; l++) if (ln[l]) r[l*8 +: 8] = nw[l*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit          wr, busy_prev;
    int          k, wa, n;
    logic [15:0] wd, v;
    logic [1:0]  wl;
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      n = n_of(i);
      if (!rst_n) begin
        exp_rd[i] = '0; exp_vld[i] = 0; exp_busy[i] = 0; exp_done[i] = 0; fill_act[i] = 0;
        continue;
      end
      busy_prev = exp_busy[i];
      wr = 0; wa = 0; wd = '0; wl = '0;
      if (busy_prev) begin
        k = ecnt - fill_s[i] - 1;
        if (k < n) begin wr = 1; wa = k; wd = fill_v[i]; wl = 2'b11; end
      end else if (we && int'(waddr) < n) begin
        wr = 1; wa = int'(waddr); wd = wdata; wl = wlanes;
      end
      if (re) begin
        if (int'(raddr) >= n) exp_rd[i] = '0;
        else begin
          v = mmem[i][raddr];
          if (i == 1 && wr && wa == int'(raddr)) v = merge(v, wd, wl);
          exp_rd[i] = v;
        end
      end
      exp_vld[i] = re;
      if (wr) mmem[i][wa] = merge(mmem[i][wa], wd, wl);
      if (!busy_prev && start) begin
        fill_act[i] = 1; fill_s[i] = ecnt; fill_v[i] = fill_data;
      end
      exp_busy[i] = fill_act[i] && (ecnt - fill_s[i]) <= n;
      exp_done[i] = fill_act[i] && (ecnt - fill_s[i]) == n;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rd0", 32'(rd0), 32'(exp_rd[0]));
    check("vld0", 32'(vld0), 32'(exp_vld[0]));
    check("busy0", 32'(busy0), 32'(exp_busy[0]));
    check("done0", 32'(done0), 32'(exp_done[0]));
    check("rd1", 32'(rd1), 32'(exp_rd[1]));
    check("vld1", 32'(vld1), 32'(exp_vld[1]));
    check("busy1", 32'(busy1), 32'(exp_busy[1]));
    check("done1", 32'(done1), 32'(exp_done[1]));
  endtask

  task automatic idle();
    we = 0; re = 0; start = 0; wlanes = 2'b11;
  endtask

  task automatic wr_word(input logic [8:0] a, input logic [15:0] d, input logic [1:0] ln);
    idle(); we = 1; waddr = a; wdata = d; wlanes = ln; step(); idle();
  endtask

  task automatic rd_word(input logic [8:0] a);
    idle(); re = 1; raddr = a; step(); idle();
  endtask

  int bc0, bc1, dc0, dc1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      exp_rd[i] = '0; exp_vld[i] = 0; exp_busy[i] = 0; exp_done[i] = 0; fill_act[i] = 0; fill_s[i] = 0;
    end
    idle(); rst_n = 0; waddr = '0; wdata = '0; raddr = '0; fill_data = '0;
    step(); step();
    check("rst_rd0", 32'(rd0), 32'h0);
    check("rst_busy1", 32'(busy1), 32'h0);
    rst_n = 1; step();

    // Initial sweep gives every element a known value; also measures busy length.
    fill_data = 16'h1111; start = 1; step(); start = 0;
    bc0 = int'(busy0); bc1 = int'(busy1); dc0 = 0; dc1 = 0;
    for (int j = 1; j < 700; j++) begin
      step();
      bc0 += int'(busy0); bc1 += int'(busy1); dc0 += int'(done0); dc1 += int'(done1);
      if (!busy0 && !busy1) break;
    end
    check("fill1_busy0", bc0, 513);
    check("fill1_busy1", bc1, 301);
    check("fill1_done0", dc0, 1);
    check("fill1_done1", dc1, 1);

    // Lane writes
    wr_word(9'd5, 16'hABCD, 2'b11);
    wr_word(9'd5, 16'h1234, 2'b01);
    rd_word(9'd5);
    check("lane_rd0", 32'(rd0), 32'hAB34);
    check("lane_vld0", 32'(vld0), 32'h1);
    check("lane_rd1", 32'(rd1), 32'hAB34);
    step();
    check("lane_vld_drop", 32'(vld0), 32'h0);
    check("lane_hold", 32'(rd0), 32'hAB34);
    wr_word(9'd7, 16'hFFFF, 2'b00);
    rd_word(9'd7);
    check("nolane_rd0", 32'(rd0), 32'h1111);

    // Read-during-write at the same address
    wr_word(9'd3, 16'h0055, 2'b11);
    idle(); we = 1; waddr = 9'd3; wdata = 16'h00AA; re = 1; raddr = 9'd3; step(); idle();
    check("rdw_old", 32'(rd0), 32'h0055);
    check("rdw_new", 32'(rd1), 32'h00AA);
    rd_word(9'd3);
    check("rdw_after", 32'(rd0), 32'h00AA);

    // Fill with reads in flight and a dropped mid-fill user write
    wr_word(9'd10, 16'h0BAD, 2'b11);
    fill_data = 16'h007E; start = 1; step(); start = 0;
    bc0 = int'(busy0); bc1 = int'(busy1); dc0 = 0; dc1 = 0;
    for (int j = 1; j < 700; j++) begin
      idle();
      re = (j == 5 || j == 20); raddr = 9'd10;
      we = (j == 50); waddr = 9'd200; wdata = 16'hDEAD;
      step();
      if (j == 5) begin
        check("inflight_old0", 32'(rd0), 32'h0BAD);
        check("inflight_old1", 32'(rd1), 32'h0BAD);
      end
      if (j == 20) begin
        check("inflight_new0", 32'(rd0), 32'h007E);
        check("inflight_new1", 32'(rd1), 32'h007E);
      end
      bc0 += int'(busy0); bc1 += int'(busy1); dc0 += int'(done0); dc1 += int'(done1);
      if (!busy0 && !busy1) break;
    end
    idle();
    check("fill2_busy0", bc0, 513);
    check("fill2_done0", dc0, 1);
    check("fill2_done1", dc1, 1);
    rd_word(9'd0);   check("fill_a0", 32'(rd0), 32'h007E);
    rd_word(9'd255); check("fill_a255", 32'(rd0), 32'h007E);
    rd_word(9'd511); check("fill_a511", 32'(rd0), 32'h007E);
    check("fill_oob1", 32'(rd1), 32'h0);
    rd_word(9'd200); check("fill_drop_wr", 32'(rd0), 32'h007E);

    // Reset part-way through a fill
    wr_word(9'd400, 16'h4000, 2'b11);
    wr_word(9'd50, 16'h0050, 2'b11);
    fill_data = 16'h3C3C; start = 1; step(); start = 0;
    for (int j = 1; j < 100; j++) step();
    rst_n = 0; step();
    check("abort_busy0", 32'(busy0), 32'h0);
    check("abort_rd0", 32'(rd0), 32'h0);
    dc0 = 0;
    for (int j = 0; j < 3; j++) begin step(); dc0 += int'(done0); end
    rst_n = 1;
    for (int j = 0; j < 3; j++) begin step(); dc0 += int'(done0) + int'(busy0); end
    check("abort_no_done", dc0, 0);
    rd_word(9'd50);  check("abort_a50", 32'(rd0), 32'h3C3C);
    rd_word(9'd400); check("abort_a400", 32'(rd0), 32'h4000);

    // Address bounds on the 300-deep instance
    wr_word(9'd310, 16'hBEEF, 2'b11);
    rd_word(9'd310);
    check("oob_rd1", 32'(rd1), 32'h0);
    check("oob_vld1", 32'(vld1), 32'h1);
    check("oob_rd0", 32'(rd0), 32'hBEEF);
    rd_word(9'd54);
    check("oob_alias1", 32'(rd1), 32'h3C3C);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(399) != 0);
      we        = $urandom_range(1);
      wlanes    = 2'($urandom_range(3));
      waddr     = 9'($urandom_range(511));
      wdata     = 16'($urandom);
      re        = $urandom_range(1);
      raddr     = ($urandom_range(3) == 0) ? waddr : 9'($urandom_range(511));
      start     = ($urandom_range(149) == 0);
      fill_data = 16'($urandom);
      step();
    end
    idle(); rst_n = 1; step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
